// File: rtl/fft_pkg.sv
// Shared constants, FSM state and stream tag type for the fft_frame_ctrl block.
package fft_pkg;

  localparam int unsigned NBITS     = 10;
  localparam int unsigned NBITS_OUT = 10;
  localparam int unsigned N         = 128;
  localparam int unsigned FB        = N / 4;
  localparam int unsigned LAT       = 14;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic valid;
    logic sof;
    logic eof;
  } tag_t;

endpackage

// File: rtl/fft_tag_delay.sv
// Fixed-depth shift register carrying the {valid, sof, eof} tag alongside the
// core pipeline. Asynchronous active-low clear drops every in-flight tag.
module fft_tag_delay
  import fft_pkg::*;
#(
  parameter int unsigned DEPTH = LAT
) (
  input  logic clk,
  input  logic rst,
  input  tag_t d,
  output tag_t q
);

  tag_t sr [DEPTH];

  // Shift the tag one stage per cycle; reset empties the whole line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the 4-lane topfft core: aligns input frames to the
// core's fixed phase, zero-fills idle/underrun beats, drives the core reset
// and re-tags the core output stream.
// Optional: define FFT_FRAME_CTRL_STATS_EN to add stat_frames/stat_underruns.
module fft_frame_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned NBITS     = fft_pkg::NBITS,
  parameter int unsigned NBITS_OUT = fft_pkg::NBITS_OUT,
  parameter int unsigned N         = fft_pkg::N,
  parameter int unsigned LAT       = fft_pkg::LAT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [8*NBITS-1:0]       in_data,
  output logic                     fft_rst,
  output logic [2*NBITS-1:0]       fft_in0_up,
  output logic [2*NBITS-1:0]       fft_in0_down,
  output logic [2*NBITS-1:0]       fft_in1_up,
  output logic [2*NBITS-1:0]       fft_in1_down,
  input  logic [2*NBITS_OUT-1:0]   fft_out0_up,
  input  logic [2*NBITS_OUT-1:0]   fft_out0_down,
  input  logic [2*NBITS_OUT-1:0]   fft_out1_up,
  input  logic [2*NBITS_OUT-1:0]   fft_out1_down,
  output logic                     out_valid,
  output logic                     out_sof,
  output logic                     out_eof,
  output logic [8*NBITS_OUT-1:0]   out_data,
`ifdef FFT_FRAME_CTRL_STATS_EN
  output logic [15:0]              stat_frames,
  output logic [15:0]              stat_underruns,
`endif
  output logic                     err_underrun
);

  localparam int unsigned BEATS = N / 4;
  localparam int unsigned PW    = $clog2(BEATS);
  localparam logic [PW-1:0] PH_LAST = PW'(BEATS - 1);

  state_t        state, state_nxt;
  logic [PW-1:0] ph;
  logic          start, push, underrun, take;
  tag_t          tag_in, tag_out;

  // Core reset: held high through rst, released on the first edge after it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fft_rst <= 1'b1;
    else      fft_rst <= 1'b0;
  end

  // Phase counter locked to the core commutator: frozen at 0 while the core is in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                ph <= '0;
    else if (fft_rst)        ph <= '0;
    else if (ph == PH_LAST)  ph <= '0;
    else                     ph <= ph + 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM next state: a frame starts only at phase 0 and always runs to the last phase.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (ph == PH_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: handshake, frame push and underrun detection.
  always_comb begin
    in_ready = 1'b0;
    start    = 1'b0;
    push     = 1'b0;
    underrun = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !fft_rst && (ph == '0);
        start    = in_ready && in_valid;
        push     = start;
      end
      RUN: begin
        in_ready = 1'b1;
        push     = 1'b1;
        underrun = !in_valid;
      end
      default: ;
    endcase
  end

  assign take = push & in_valid;

  // Core input registers and input-side tag; missing or idle beats become zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fft_in0_up   <= '0;
      fft_in0_down <= '0;
      fft_in1_up   <= '0;
      fft_in1_down <= '0;
      tag_in       <= '0;
      err_underrun <= 1'b0;
    end else begin
      fft_in0_up   <= take ? in_data[2*NBITS-1:0]       : '0;
      fft_in0_down <= take ? in_data[4*NBITS-1:2*NBITS] : '0;
      fft_in1_up   <= take ? in_data[6*NBITS-1:4*NBITS] : '0;
      fft_in1_down <= take ? in_data[8*NBITS-1:6*NBITS] : '0;
      tag_in.valid <= push;
      tag_in.sof   <= push && (ph == '0);
      tag_in.eof   <= push && (ph == PH_LAST);
      err_underrun <= underrun;
    end
  end

  fft_tag_delay #(
    .DEPTH (LAT)
  ) u_tag_delay (
    .clk (clk),
    .rst (rst),
    .d   (tag_in),
    .q   (tag_out)
  );

  // Output stage: markers follow the delayed tag; data only moves on valid beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= tag_out.valid;
      out_sof   <= tag_out.sof;
      out_eof   <= tag_out.eof;
      if (tag_out.valid)
        out_data <= {fft_out1_down, fft_out1_up, fft_out0_down, fft_out0_up};
    end
  end

`ifdef FFT_FRAME_CTRL_STATS_EN
  // Saturating frame and underrun-beat counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_frames    <= '0;
      stat_underruns <= '0;
    end else begin
      if (start && (stat_frames != '1))       stat_frames    <= stat_frames + 16'd1;
      if (underrun && (stat_underruns != '1)) stat_underruns <= stat_underruns + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl. The core is stood in for by a LAT-stage
// delay line, so each output beat equals the pushed input beat.
module tb_fft_frame_ctrl;

  localparam int LAT = 14;
  localparam int REC = 2048;
  localparam logic [79:0] IMP = {60'd0, 10'd255, 10'd0};

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [79:0] in_data;
  logic        fft_rst;
  logic [19:0] fft_in0_up, fft_in0_down, fft_in1_up, fft_in1_down;
  logic [19:0] fft_out0_up, fft_out0_down, fft_out1_up, fft_out1_down;
  logic        out_valid, out_sof, out_eof;
  logic [79:0] out_data;
  logic        err_underrun;
`ifdef FFT_FRAME_CTRL_STATS_EN
  logic [15:0] stat_frames, stat_underruns;
`endif

  fft_frame_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .fft_rst       (fft_rst),
    .fft_in0_up    (fft_in0_up),
    .fft_in0_down  (fft_in0_down),
    .fft_in1_up    (fft_in1_up),
    .fft_in1_down  (fft_in1_down),
    .fft_out0_up   (fft_out0_up),
    .fft_out0_down (fft_out0_down),
    .fft_out1_up   (fft_out1_up),
    .fft_out1_down (fft_out1_down),
    .out_valid     (out_valid),
    .out_sof       (out_sof),
    .out_eof       (out_eof),
    .out_data      (out_data),
`ifdef FFT_FRAME_CTRL_STATS_EN
    .stat_frames   (stat_frames),
    .stat_underruns(stat_underruns),
`endif
    .err_underrun  (err_underrun)
  );

  always #5 clk = ~clk;

  // Core stand-in: pure LAT-cycle delay, cleared by the core reset.
  logic [79:0] fin_vec;
  logic [79:0] pipe [LAT];
  assign fin_vec = {fft_in1_down, fft_in1_up, fft_in0_down, fft_in0_up};
  always @(posedge clk) begin
    if (fft_rst) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= fin_vec;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign fft_out0_up   = pipe[LAT-1][19:0];
  assign fft_out0_down = pipe[LAT-1][39:20];
  assign fft_out1_up   = pipe[LAT-1][59:40];
  assign fft_out1_down = pipe[LAT-1][79:60];

  // Cycle index and per-cycle trace sampled mid-cycle.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rdy [REC];
  logic        iv  [REC];
  logic        und [REC];
  logic        ov  [REC];
  logic        os  [REC];
  logic        oe  [REC];
  logic [79:0] fin [REC];
  logic [79:0] od  [REC];

  always @(negedge clk) begin
    if (cyc < REC) begin
      rdy[cyc] <= in_ready;
      iv[cyc]  <= in_valid;
      und[cyc] <= err_underrun;
      ov[cyc]  <= out_valid;
      os[cyc]  <= out_sof;
      oe[cyc]  <= out_eof;
      fin[cyc] <= fin_vec;
      od[cyc]  <= out_data;
    end
  end

  int checks = 0;
  int errors = 0;
  int r;

  function automatic logic [79:0] beat(input int k);
    logic [19:0] b;
    b = 20'(k * 4);
    return {b + 20'd4, b + 20'd3, b + 20'd2, b + 20'd1};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(output int rel);
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) step();
    rst = 1'b1;
    rel = cyc;
  endtask

  // Offers beats base.. one per accepted handshake; optional gap before beat gap_at.
  task automatic stream(input int ncyc, input int base, input int max_beats,
                        input int gap_at, input int gap_len, input bit impulse);
    int k = 0;
    int g = 0;
    for (int c = 0; c < ncyc; c++) begin
      step();
      if (iv[cyc-1] && rdy[cyc-1]) k++;
      if (k >= max_beats) begin
        in_valid = 1'b0;
      end else if (k == gap_at && g < gap_len) begin
        in_valid = 1'b0;
        g++;
      end else begin
        in_valid = 1'b1;
        in_data  = impulse ? ((k == 0) ? IMP : '0) : beat(base + k);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) step();
    checks++; if (fft_rst !== 1'b1)   begin errors++; $display("FAIL rst_fft_rst got %b exp 1", fft_rst); end
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    checks++; if (fin_vec !== '0)     begin errors++; $display("FAIL rst_fft_in got %h exp 0", fin_vec); end
    checks++; if ({out_valid, out_sof, out_eof} !== 3'b000) begin errors++; $display("FAIL rst_out_tags got %b exp 000", {out_valid, out_sof, out_eof}); end
    checks++; if (out_data !== '0)    begin errors++; $display("FAIL rst_out_data got %h exp 0", out_data); end
    checks++; if (err_underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun got %b exp 0", err_underrun); end
    rst = 1'b1; in_valid = 1'b1; in_data = beat(0);
    r = cyc;
    #1;
    checks++; if (fft_rst !== 1'b1)   begin errors++; $display("FAIL rel_fft_rst_hold got %b exp 1", fft_rst); end
    step();
    checks++; if (fft_rst !== 1'b0)   begin errors++; $display("FAIL rel_fft_rst_fall got %b exp 0", fft_rst); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rel_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_latency();
    int h = -1;
    int s = -1;
    int e = -1;
    stream(60, 0, 32, -1, 0, 1'b0);
    checks++; if (rdy[r] !== 1'b0) begin errors++; $display("FAIL lat_ready_in_reset got %b exp 0", rdy[r]); end
    for (int c = r; c < r + 10; c++) if (h < 0 && iv[c] && rdy[c]) h = c;
    checks++; if (h !== r + 1) begin errors++; $display("FAIL lat_accept_cycle got %0d exp %0d", h - r, 1); end
    checks++; if (fin[r+2] !== beat(0)) begin errors++; $display("FAIL lat_fft_in_b0 got %h exp %h", fin[r+2], beat(0)); end
    checks++; if (fin[r+3] !== beat(1)) begin errors++; $display("FAIL lat_fft_in_b1 got %h exp %h", fin[r+3], beat(1)); end
    for (int c = r; c < r + 60; c++) if (s < 0 && os[c]) s = c;
    checks++; if (s !== r + 1 + LAT + 2) begin errors++; $display("FAIL lat_sof_delay got %0d exp %0d", s - (r + 1), LAT + 2); end
    for (int c = r; c < r + 60; c++) if (e < 0 && oe[c]) e = c;
    checks++; if (e - s !== 31) begin errors++; $display("FAIL lat_eof_after_sof got %0d exp 31", e - s); end
    checks++; if (od[r+17] !== beat(0)) begin errors++; $display("FAIL lat_out_b0 got %h exp %h", od[r+17], beat(0)); end
  endtask

  task automatic test_hold();
    int zeros = 0;
    apply_reset(r);
    for (int c = 0; c < 10; c++) if (cyc < r + 5) step();
    stream(40, 100, 1, -1, 0, 1'b0);
    for (int c = r + 6; c <= r + 32; c++) if (rdy[c] === 1'b0 && iv[c] === 1'b1) zeros++;
    checks++; if (zeros !== 27) begin errors++; $display("FAIL hold_not_ready got %0d exp 27", zeros); end
    checks++; if (rdy[r+33] !== 1'b1) begin errors++; $display("FAIL hold_ready_ph0 got %b exp 1", rdy[r+33]); end
    checks++; if (fin[r+33] !== '0) begin errors++; $display("FAIL hold_idle_zero got %h exp 0", fin[r+33]); end
    checks++; if (fin[r+34] !== beat(100)) begin errors++; $display("FAIL hold_beat0 got %h exp %h", fin[r+34], beat(100)); end
  endtask

  task automatic test_back_to_back();
    int s;
    apply_reset(r);
    stream(90, 300, 64, -1, 0, 1'b0);
    s = r + 17;
    checks++; if (ov[s-1] !== 1'b0) begin errors++; $display("FAIL b2b_pre_valid got %b exp 0", ov[s-1]); end
    for (int j = 0; j < 64; j++) begin
      checks++; if (ov[s+j] !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %b exp 1", j, ov[s+j]); end
      checks++; if (os[s+j] !== (j == 0 || j == 32)) begin errors++; $display("FAIL b2b_sof[%0d] got %b exp %b", j, os[s+j], (j == 0 || j == 32)); end
      checks++; if (oe[s+j] !== (j == 31 || j == 63)) begin errors++; $display("FAIL b2b_eof[%0d] got %b exp %b", j, oe[s+j], (j == 31 || j == 63)); end
      checks++; if (od[s+j] !== beat(300 + j)) begin errors++; $display("FAIL b2b_data[%0d] got %h exp %h", j, od[s+j], beat(300 + j)); end
    end
    checks++; if (ov[s+64] !== 1'b0) begin errors++; $display("FAIL b2b_post_valid got %b exp 0", ov[s+64]); end
    checks++; if (od[s+64] !== beat(363)) begin errors++; $display("FAIL b2b_data_hold got %h exp %h", od[s+64], beat(363)); end
  endtask

  task automatic test_underrun();
    int h;
    int s;
    int pulses = 0;
    apply_reset(r);
    stream(60, 200, 29, 10, 3, 1'b0);
    h = r + 1;
    s = h + LAT + 2;
    for (int j = 10; j <= 12; j++) begin
      checks++; if (und[h+1+j] !== 1'b1) begin errors++; $display("FAIL udr_pulse[%0d] got %b exp 1", j, und[h+1+j]); end
      checks++; if (fin[h+1+j] !== '0) begin errors++; $display("FAIL udr_zero[%0d] got %h exp 0", j, fin[h+1+j]); end
    end
    for (int c = r; c < r + 60; c++) if (und[c] === 1'b1) pulses++;
    checks++; if (pulses !== 3) begin errors++; $display("FAIL udr_pulse_count got %0d exp 3", pulses); end
    checks++; if (fin[h+10] !== beat(209)) begin errors++; $display("FAIL udr_before got %h exp %h", fin[h+10], beat(209)); end
    checks++; if (fin[h+14] !== beat(210)) begin errors++; $display("FAIL udr_after got %h exp %h", fin[h+14], beat(210)); end
    checks++; if (os[s] !== 1'b1) begin errors++; $display("FAIL udr_sof got %b exp 1", os[s]); end
    checks++; if (oe[s+31] !== 1'b1) begin errors++; $display("FAIL udr_eof got %b exp 1", oe[s+31]); end
    checks++; if (ov[s+32] !== 1'b0) begin errors++; $display("FAIL udr_end got %b exp 0", ov[s+32]); end
    checks++; if ({ov[s+10], od[s+10]} !== {1'b1, 80'd0}) begin errors++; $display("FAIL udr_out_zero got %b/%h exp 1/0", ov[s+10], od[s+10]); end
    checks++; if (od[s+13] !== beat(210)) begin errors++; $display("FAIL udr_out_resume got %h exp %h", od[s+13], beat(210)); end
`ifdef FFT_FRAME_CTRL_STATS_EN
    checks++; if (stat_underruns !== 16'd3) begin errors++; $display("FAIL udr_stat_underruns got %0d exp 3", stat_underruns); end
    checks++; if (stat_frames !== 16'd1) begin errors++; $display("FAIL udr_stat_frames got %0d exp 1", stat_frames); end
`endif
  endtask

  task automatic test_abort();
    int r2;
    int s = -1;
    apply_reset(r);
    stream(21, 400, 32, -1, 0, 1'b0);
    in_valid = 1'b1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL abort_pre_valid got %b exp 1", out_valid); end
    #2 rst = 1'b0;
    #1;
    checks++; if (fft_rst !== 1'b1) begin errors++; $display("FAIL abort_fft_rst got %b exp 1", fft_rst); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_in_ready got %b exp 0", in_ready); end
    checks++; if (fin_vec !== '0) begin errors++; $display("FAIL abort_fft_in got %h exp 0", fin_vec); end
    checks++; if ({out_valid, out_sof, out_eof} !== 3'b000) begin errors++; $display("FAIL abort_out_tags got %b exp 000", {out_valid, out_sof, out_eof}); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL abort_out_data got %h exp 0", out_data); end
    in_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    r2 = cyc;
    stream(60, 500, 32, -1, 0, 1'b0);
    for (int c = r2 - 2; c < r2 + 60; c++) if (s < 0 && ov[c]) s = c;
    checks++; if (s !== r2 + 17) begin errors++; $display("FAIL abort_first_valid got %0d exp 17", s - r2); end
    checks++; if (os[r2+17] !== 1'b1) begin errors++; $display("FAIL abort_realign_sof got %b exp 1", os[r2+17]); end
    checks++; if (od[r2+17] !== beat(500)) begin errors++; $display("FAIL abort_realign_data got %h exp %h", od[r2+17], beat(500)); end
`ifdef FFT_FRAME_CTRL_STATS_EN
    checks++; if (stat_frames !== 16'd1) begin errors++; $display("FAIL abort_stat_frames got %0d exp 1", stat_frames); end
`endif
  endtask

  task automatic test_impulse();
    int s;
    apply_reset(r);
    stream(60, 0, 32, -1, 0, 1'b1);
    s = r + 17;
    for (int j = 0; j < 32; j++) begin
      checks++; if (ov[s+j] !== 1'b1) begin errors++; $display("FAIL imp_valid[%0d] got %b exp 1", j, ov[s+j]); end
      checks++; if (od[s+j] !== ((j == 0) ? IMP : 80'd0)) begin errors++; $display("FAIL imp_data[%0d] got %h exp %h", j, od[s+j], (j == 0) ? IMP : 80'd0); end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_hold();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_impulse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

Frame sequencer for the 4-lane parallel `topfft` core (N = 128). It accepts a valid/ready beat stream of four complex samples per beat and aligns each frame to the core's fixed internal frame phase. It pushes every frame contiguously, zero-fills idle or underrun beats, drives the core's active-high reset, and re-tags the core's output stream with valid/sof/eof markers after the core's pipeline latency.

## Interface
- `NBITS`, 10, input real/imag width; one complex sample is {re, im}, 2*NBITS bits
- `NBITS_OUT`, 10, core output real/imag width
- `N`, 128, FFT length; beats per frame `FB` = N/4 = 32
- `LAT`, 14, core latency in cycles, from `fft_in*` to the corresponding `fft_out*`; must be ≥1

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  beat valid
- `in_ready`  out  1  beat accepted when `in_valid & in_ready`
- `in_data`  in  8*NBITS  lanes [2NB-1:0]=in0_up, then in0_down, in1_up, in1_down
- `fft_rst`  out  1  active-high reset to the core
- `fft_in0_up`, `fft_in0_down`, `fft_in1_up`, `fft_in1_down`  out  2*NBITS each  core inputs, registered
- `fft_out0_up`, `fft_out0_down`, `fft_out1_up`, `fft_out1_down`  in  2*NBITS_OUT each  core outputs
- `out_valid`  out  1  output beat valid
- `out_sof`, `out_eof`  out  1  first / last beat of an output frame
- `out_data`  out  8*NBITS_OUT  core outputs, registered, same lane order as `in_data`
- `err_underrun`  out  1  one-cycle pulse when an in-frame beat is missing

## Operation
- Phase counter `ph`, range 0..FB-1, increments every cycle and wraps FB-1→0. It is held at 0 while `fft_rst`=1, which keeps it locked to the core's internal commutator phase.
- State IDLE / RUN.
  - IDLE: `in_ready` = (ph==0). An accepted beat at ph==0 moves the block to RUN and is frame beat 0.
  - RUN: `in_ready`=1. Each cycle consumes one beat.
  - RUN → IDLE on the cycle ph==FB-1.
  - Back-to-back frames: the first beat of the next frame is accepted at ph==0 directly from IDLE with no gap.
- Underrun: in RUN with `in_valid`=0, a zero beat is pushed, `err_underrun` pulses, and the frame continues. A frame is never aborted.
- Outside frames, `fft_in*` are driven with zero.
- Tag path: {valid, sof, eof} is registered alongside `fft_in*` and delayed a further LAT cycles. It then qualifies `fft_out*` into the `out_*` registers.
  - sof is set at ph==0; eof is set at ph==FB-1.
  - An underrun beat still carries valid=1.
- `out_data` updates only when the delayed valid=1; otherwise it holds its value.

## Timing
- Beat accepted at edge t → `fft_in*` at t+1 → `fft_out*` at t+1+LAT → `out_valid`/`out_data` at t+2+LAT. Total latency is LAT+2 cycles; at the default that is 16.
- `fft_rst`: reset value 1; cleared on the first `clk` edge after `rst` releases. The phase counter starts counting from the following edge.
- Reset values: `in_ready`=0, `fft_in*`=0, `out_valid`=`out_sof`=`out_eof`=0, `out_data`=0, `err_underrun`=0, state IDLE, ph=0, tag delay line all 0.
- Reset asserted mid-frame: all state clears immediately, the in-flight tags are discarded, and the core is reset through `fft_rst`.
- `in_valid` high at ph≠0 in IDLE: not accepted; the data must be held until ph==0.

## Configuration
- `FFT_FRAME_CTRL_STATS_EN` defined: adds outputs `stat_frames` [15:0] and `stat_underruns` [15:0].
  - `stat_frames` counts frames started; `stat_underruns` counts underrun beats.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: neither the ports nor the counters exist. All other behaviour is identical.

## Structure
- Shared package `fft_pkg` holds:
  - constants NBITS, NBITS_OUT, N, FB, LAT
  - the state enum {IDLE, RUN}
  - the tag struct {valid, sof, eof}
- Sub-module `fft_tag_delay`: a parameterised-depth shift register (depth LAT) for the tag struct, with async active-low clear.

## Test plan
- Reset release, `in_valid`=1 constant → `fft_rst` falls 1 cycle after release. The first beat is accepted at ph==0, and `out_sof`=1 exactly LAT+2 cycles after acceptance. `out_eof` follows 31 cycles after `out_sof`.
- `in_valid` asserted at ph==5 → `in_ready`=0 until ph==0 (27 cycles later). Then frame beat 0 equals the held data.
- Two back-to-back frames → 64 consecutive `out_valid` beats; `out_sof` on beats 0 and 32, `out_eof` on beats 31 and 63.
- `in_valid` dropped at frame beat 10 for 3 cycles → `err_underrun` pulses 3 times; `fft_in*`=0 on those beats. The frame still ends at ph==31, and with stats enabled `stat_underruns`=3.
- `rst` pulsed low at frame beat 20 → all outputs go to 0 asynchronously. No `out_valid` appears from the aborted frame, and the next frame aligns to ph==0.
- Impulse frame: beat 0 lane 0 = {10'd255, 10'd0}, all others zero → `out_data` matches the reference model file beat-for-beat, compared with `===`.
